rng_conf_exec: RTL

//  Datapath/sequencer partner of the RNG self-calibration next-state logic (fsm_comb_rng).

---
 rtl/rng_conf_if.sv | 40 ++++
 rtl/rng_conf_exec.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rng_conf_if.sv
// rng_conf_if: bundles the FSM/RNG-facing signals of rng_conf_exec.
//   pres_state  5  current calibration FSM state code
//   rng_bit     1  raw RNG bit, already synchronised to clk
//   rng_valid   1  rng_bit qualifier, one sample per high cycle
//   nconf1..clkconf0  4 each  trim registers
//   bit_a..bit_d      1 each  sampled random bits for the FSM
//   state_adv   1  one-cycle pulse, FSM state register may load
//   busy        1  trim update / settle / sample in progress
//   sat_err     1  sticky saturation flag
// Modports: master drives pres_state/rng_*, slave (rng_conf_exec) drives the rest.
interface rng_conf_if;
  logic [4:0] pres_state;
  logic       rng_bit;
  logic       rng_valid;
  logic [3:0] nconf1;
  logic [3:0] nconf0;
  logic [3:0] pconf1;
  logic [3:0] pconf0;
  logic [3:0] clkconf1;
  logic [3:0] clkconf0;
  logic       bit_a;
  logic       bit_b;
  logic       bit_c;
  logic       bit_d;
  logic       state_adv;
  logic       busy;
  logic       sat_err;

  modport master (
    output pres_state, rng_bit, rng_valid,
    input  nconf1, nconf0, pconf1, pconf0, clkconf1, clkconf0,
    input  bit_a, bit_b, bit_c, bit_d, state_adv, busy, sat_err
  );

  modport slave (
    input  pres_state, rng_bit, rng_valid,
    output nconf1, nconf0, pconf1, pconf0, clkconf1, clkconf0,
    output bit_a, bit_b, bit_c, bit_d, state_adv, busy, sat_err
  );
endinterface

// File: rtl/rng_conf_exec.sv
// rng_conf_exec: datapath/sequencer partner of the RNG self-calibration FSM.
// Holds six 4-bit trim registers, executes the inc/dec action encoded by pres_state,
// waits SETTLE_CYC cycles for the analog RNG to settle, samples four fresh random bits
// into bit_a..bit_d and then pulses state_adv so the FSM may advance.
// Ports:
//   clk    single clock, all state on rising edge
//   rst_n  synchronous reset, active low
//   bus    rng_conf_if.slave (pres_state, rng_bit, rng_valid in; trims, bits,
//          state_adv, busy, sat_err out)
// Optional feature: define RNG_CONF_DEBIAS_EN to run von Neumann debiasing on the
// raw bit stream while sampling (01 -> 0, 10 -> 1, 00/11 discarded).
module rng_conf_exec #(
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned SETTLE_W     = 5,
  parameter logic [3:0]  CONF_INIT    = 4'd8,
  parameter logic [3:0]  NCONF1_MIN   = 4'd0,
  parameter logic [3:0]  NCONF0_MAX   = 4'd15,
  parameter logic [3:0]  PCONF1_MIN   = 4'd0,
  parameter logic [3:0]  PCONF0_MAX   = 4'd15,
  parameter logic [3:0]  CLKCONF1_MIN = 4'd0,
  parameter logic [3:0]  CLKCONF0_MAX = 4'd15
) (
  input logic       clk,
  input logic       rst_n,
  rng_conf_if.slave bus
);

  typedef enum logic [2:0] {StEval, StApply, StSettle, StSample, StAdv} seq_e;

  // Trim index: even entries (xconf1) only decrement, odd entries (xconf0) only increment.
  localparam logic [5:0][3:0] Limit = {CLKCONF0_MAX, CLKCONF1_MIN, PCONF0_MAX,
                                       PCONF1_MIN, NCONF0_MAX, NCONF1_MIN};

  seq_e                  seq_q, seq_d;
  logic [5:0][3:0]       conf_q, conf_d;
  logic [2:0]            tgt_q, tgt_d;
  logic [SETTLE_W-1:0]   cnt_q, cnt_d;
  logic [1:0]            nacc_q, nacc_d;
  logic [2:0]            acc_q, acc_d;
  logic [3:0]            bits_q, bits_d;
  logic                  sat_q, sat_d;
  logic                  accept;
  logic                  acc_bit;
`ifdef RNG_CONF_DEBIAS_EN
  logic                  pair_vld_q, pair_vld_d;
  logic                  pair_bit_q, pair_bit_d;
`endif

  always_comb begin
    seq_d   = seq_q;
    conf_d  = conf_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    nacc_d  = nacc_q;
    acc_d   = acc_q;
    bits_d  = bits_q;
    sat_d   = sat_q;
    accept  = 1'b0;
    acc_bit = bus.rng_bit;
`ifdef RNG_CONF_DEBIAS_EN
    pair_vld_d = pair_vld_q;
    pair_bit_d = pair_bit_q;
`endif
    unique case (seq_q)
      StEval: begin
        nacc_d = 2'd0;
`ifdef RNG_CONF_DEBIAS_EN
        pair_vld_d = 1'b0;
`endif
        case (bus.pres_state)
          5'd2:    begin tgt_d = 3'd0; seq_d = StApply; end
          5'd4:    begin tgt_d = 3'd1; seq_d = StApply; end
          5'd6:    begin tgt_d = 3'd2; seq_d = StApply; end
          5'd8:    begin tgt_d = 3'd3; seq_d = StApply; end
          5'd10:   begin tgt_d = 3'd4; seq_d = StApply; end
          5'd12:   begin tgt_d = 3'd5; seq_d = StApply; end
          5'd0:    seq_d = StSample;
          default: seq_d = StAdv;
        endcase
      end
      StApply: begin
        // At the limit the trim holds and the error sticks; settle+sample still run.
        if (tgt_q[0]) begin
          if (conf_q[tgt_q] >= Limit[tgt_q]) sat_d = 1'b1;
          else conf_d[tgt_q] = conf_q[tgt_q] + 4'd1;
        end else begin
          if (conf_q[tgt_q] <= Limit[tgt_q]) sat_d = 1'b1;
          else conf_d[tgt_q] = conf_q[tgt_q] - 4'd1;
        end
        cnt_d = SETTLE_W'(SETTLE_CYC - 1);
        seq_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) seq_d = StSample;
        else cnt_d = cnt_q - 1'b1;
      end
      StSample: begin
`ifdef RNG_CONF_DEBIAS_EN
        if (bus.rng_valid) begin
          if (!pair_vld_q) begin
            pair_vld_d = 1'b1;
            pair_bit_d = bus.rng_bit;
          end else begin
            pair_vld_d = 1'b0;
            accept     = (pair_bit_q != bus.rng_bit);
            acc_bit    = pair_bit_q;
          end
        end
`else
        accept = bus.rng_valid;
`endif
        if (accept) begin
          acc_d  = {acc_q[1:0], acc_bit};
          nacc_d = nacc_q + 2'd1;
          if (nacc_q == 2'd3) begin
            bits_d = {acc_q, acc_bit};
            seq_d  = StAdv;
          end
        end
      end
      StAdv:   seq_d = StEval;
      default: seq_d = StEval;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q  <= StEval;
      conf_q <= {6{CONF_INIT}};
      tgt_q  <= '0;
      cnt_q  <= '0;
      nacc_q <= '0;
      acc_q  <= '0;
      bits_q <= '0;
      sat_q  <= 1'b0;
`ifdef RNG_CONF_DEBIAS_EN
      pair_vld_q <= 1'b0;
      pair_bit_q <= 1'b0;
`endif
    end else begin
      seq_q  <= seq_d;
      conf_q <= conf_d;
      tgt_q  <= tgt_d;
      cnt_q  <= cnt_d;
      nacc_q <= nacc_d;
      acc_q  <= acc_d;
      bits_q <= bits_d;
      sat_q  <= sat_d;
`ifdef RNG_CONF_DEBIAS_EN
      pair_vld_q <= pair_vld_d;
      pair_bit_q <= pair_bit_d;
`endif
    end
  end

  assign bus.nconf1    = conf_q[0];
  assign bus.nconf0    = conf_q[1];
  assign bus.pconf1    = conf_q[2];
  assign bus.pconf0    = conf_q[3];
  assign bus.clkconf1  = conf_q[4];
  assign bus.clkconf0  = conf_q[5];
  assign bus.bit_a     = bits_q[3];
  assign bus.bit_b     = bits_q[2];
  assign bus.bit_c     = bits_q[1];
  assign bus.bit_d     = bits_q[0];
  assign bus.state_adv = (seq_q == StAdv);
  assign bus.busy      = (seq_q == StApply) || (seq_q == StSettle) || (seq_q == StSample);
  assign bus.sat_err   = sat_q;

endmodule
